pwm_bank: RTL and testbench



---
 rtl/pwm_bank.sv | 157 +++++++++++++++
 tb/tb_pwm_bank.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank with a shared counter, shadow/active thresholds committed at the
// period boundary, per-channel enable/invert, a prescaler and edge- or centre-aligned counting.
module pwm_bank #(
  parameter int pwm_width      = 8,
  parameter int num_pwm        = 12,
  parameter int prescale_width = 8,
  parameter int center_aligned = 0,
  localparam int addr_w        = (num_pwm > 1) ? $clog2(num_pwm) : 1,
  localparam int cmd_width     = pwm_width + 8 * ((addr_w + 2 + 7) / 8)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  logic [cmd_width-1:0] cmd_data,
  output logic [num_pwm-1:0]   pwm_out,
  output logic                 period_start,
  output logic                 commit_pending
);

  typedef enum logic [1:0] {
    OP_WRITE_SHADOW = 2'b00,
    OP_WRITE_CFG    = 2'b01,
    OP_COMMIT       = 2'b10,
    OP_SET_PRESCALE = 2'b11
  } op_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [pwm_width-1:0] cnt_max   = '1;
  localparam logic [pwm_width-1:0] cnt_one   = pwm_width'(1);
  localparam logic [addr_w:0]      num_pwm_l = (addr_w + 1)'(num_pwm);

  op_e                      op;
  logic [addr_w-1:0]        addr;
  logic [pwm_width-1:0]     value;
  logic [pwm_width+1:0]     value_pad;
  logic                     addr_ok;

  logic [pwm_width-1:0]     shadow [num_pwm];
  logic [pwm_width-1:0]     active [num_pwm];
  logic [num_pwm-1:0]       enable;
  logic [num_pwm-1:0]       invert;
  logic [prescale_width-1:0] reload;
  logic [prescale_width-1:0] prescaler;
  logic [pwm_width-1:0]     counter;
  dir_e                     dir;

  logic                     tick;
  logic                     boundary;
  logic [pwm_width-1:0]     cnt_next;
  dir_e                     dir_next;
  logic [num_pwm-1:0]       pwm_next;

  assign op        = op_e'(cmd_data[cmd_width-1 -: 2]);
  assign addr      = cmd_data[pwm_width +: addr_w];
  assign value     = cmd_data[pwm_width-1:0];
  // Padding keeps value bit 1 (invert) addressable when pwm_width is 1.
  assign value_pad = {2'b00, value};
  assign addr_ok   = {1'b0, addr} < num_pwm_l;
  assign tick      = (prescaler == reload);

  always_comb begin
    cnt_next = counter;
    dir_next = dir;
    boundary = 1'b0;
    if (tick) begin
      if (center_aligned == 0) begin
        if (counter == cnt_max) begin
          cnt_next = '0;
          boundary = 1'b1;
        end else begin
          cnt_next = counter + cnt_one;
        end
      end else if (dir == DIR_DOWN) begin
        if (counter == cnt_one) begin
          cnt_next = '0;
          dir_next = DIR_UP;
          boundary = 1'b1;
        end else begin
          cnt_next = counter - cnt_one;
        end
      end else if (counter == cnt_max) begin
        // With a 1-bit counter the turn at max lands directly on 0, so it is also the boundary.
        if (cnt_max == cnt_one) begin
          cnt_next = '0;
          boundary = 1'b1;
        end else begin
          cnt_next = counter - cnt_one;
          dir_next = DIR_DOWN;
        end
      end else begin
        cnt_next = counter + cnt_one;
      end
    end
  end

  always_comb begin
    pwm_next = '0;
    for (int unsigned i = 0; i < num_pwm; i++) begin
      pwm_next[i] = (enable[i] & (counter < active[i])) ^ invert[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < num_pwm; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      enable         <= '0;
      invert         <= '0;
      reload         <= '0;
      prescaler      <= '0;
      counter        <= '0;
      dir            <= DIR_UP;
      commit_pending <= 1'b0;
      period_start   <= 1'b0;
      pwm_out        <= '0;
    end else begin
      prescaler    <= tick ? '0 : prescaler + prescale_width'(1);
      counter      <= cnt_next;
      dir          <= dir_next;
      period_start <= boundary;
      pwm_out      <= pwm_next;

      // Transfer samples shadow before this edge; a COMMIT in the same cycle re-arms pending.
      if (boundary && commit_pending) begin
        for (int unsigned i = 0; i < num_pwm; i++) begin
          active[i] <= shadow[i];
        end
        commit_pending <= 1'b0;
      end

      if (cmd_valid) begin
        case (op)
          OP_WRITE_SHADOW: if (addr_ok) shadow[addr] <= value;
          OP_WRITE_CFG: begin
            if (addr_ok) begin
              enable[addr] <= value_pad[0];
              invert[addr] <= value_pad[1];
            end
          end
          OP_COMMIT:       commit_pending <= 1'b1;
          OP_SET_PRESCALE: begin
            reload    <= prescale_width'(value);
            prescaler <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Bench for pwm_bank: an edge-aligned and a centre-aligned instance share one command stream and
// are compared every cycle against a phase-based model, plus literal duty/period expectations.
module tb_pwm_bank;

  localparam int W  = 8;
  localparam int N  = 12;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [CW-1:0] cmd_data = '0;
  logic [N-1:0]  pwm_e, pwm_c;
  logic          ps_e, ps_c, cp_e, cp_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_bank #(.pwm_width(W), .num_pwm(N), .prescale_width(8), .center_aligned(0)) dut_e (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .pwm_out(pwm_e), .period_start(ps_e), .commit_pending(cp_e));

  pwm_bank #(.pwm_width(W), .num_pwm(N), .prescale_width(8), .center_aligned(1)) dut_c (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .pwm_out(pwm_c), .period_start(ps_c), .commit_pending(cp_c));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: instance k walks a phase 0..period-1 once per tick; the counter value is a
  // function of that phase (sawtooth or triangle).
  int       m_presc, m_reload;
  int       m_phase [2];
  bit       m_pend [2];
  int       m_active [2][N];
  int       m_shadow [N];
  bit       m_en [N];
  bit       m_inv [N];
  bit       exp_pwm [2][N];
  bit       exp_ps [2];
  bit       exp_cp [2];
  bit       m_tick, m_bnd;
  int       m_cnt, m_op, m_addr, m_val;

  function automatic int period_of(input int k);
    return (k == 0) ? 256 : 510;
  endfunction

  function automatic int counter_of(input int k, input int p);
    if (k == 0) return p;
    return (p <= 255) ? p : 510 - p;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_presc = 0;
      m_reload = 0;
      for (int k = 0; k < 2; k++) begin
        m_phase[k] = 0;
        m_pend[k] = 0;
        exp_ps[k] = 0;
        exp_cp[k] = 0;
        for (int i = 0; i < N; i++) begin
          m_active[k][i] = 0;
          exp_pwm[k][i] = 0;
        end
      end
      for (int i = 0; i < N; i++) begin
        m_shadow[i] = 0;
        m_en[i] = 0;
        m_inv[i] = 0;
      end
    end else begin
      m_tick = (m_presc == m_reload);
      for (int k = 0; k < 2; k++) begin
        m_cnt = counter_of(k, m_phase[k]);
        for (int i = 0; i < N; i++)
          exp_pwm[k][i] = (m_en[i] && (m_cnt < m_active[k][i])) ^ m_inv[i];
        m_bnd = m_tick && (m_phase[k] == period_of(k) - 1);
        if (m_tick) m_phase[k] = (m_phase[k] + 1) % period_of(k);
        exp_ps[k] = m_bnd;
        if (m_bnd && m_pend[k]) begin
          for (int i = 0; i < N; i++) m_active[k][i] = m_shadow[i];
          m_pend[k] = 0;
        end
      end
      m_presc = m_tick ? 0 : m_presc + 1;
      if (cmd_valid) begin
        m_op   = int'(cmd_data[15:14]);
        m_addr = int'(cmd_data[11:8]);
        m_val  = int'(cmd_data[7:0]);
        case (m_op)
          0: if (m_addr < N) m_shadow[m_addr] = m_val;
          1: if (m_addr < N) begin
               m_en[m_addr]  = m_val[0];
               m_inv[m_addr] = m_val[1];
             end
          2: begin m_pend[0] = 1; m_pend[1] = 1; end
          default: begin m_reload = m_val; m_presc = 0; end
        endcase
      end
      for (int k = 0; k < 2; k++) exp_cp[k] = m_pend[k];
    end
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("edge_pwm[%0d]", i), int'(pwm_e[i]), int'(exp_pwm[0][i]));
      check($sformatf("ctr_pwm[%0d]", i), int'(pwm_c[i]), int'(exp_pwm[1][i]));
    end
    check("edge_period_start", int'(ps_e), int'(exp_ps[0]));
    check("ctr_period_start", int'(ps_c), int'(exp_ps[1]));
    check("edge_commit_pending", int'(cp_e), int'(exp_cp[0]));
    check("ctr_commit_pending", int'(cp_c), int'(exp_cp[1]));
  end

  task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [7:0] v);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = {op, 2'b00, a, v};
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = '0;
  endtask

  function automatic logic ps_of(input int k);
    return (k == 0) ? ps_e : ps_c;
  endfunction

  task automatic wait_ps(input int k, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ps_of(k) && n < 5000);
    if (!ps_of(k)) check({name, "_timeout"}, 0, 1);
  endtask

  // Samples one whole period: from one period_start pulse up to the next.
  task automatic measure(input int k, input int ch, input string name, output int n, output int h);
    logic [N-1:0] p;
    wait_ps(k, name);
    n = 0;
    h = 0;
    do begin
      p = (k == 0) ? pwm_e : pwm_c;
      h += int'(p[ch]);
      n++;
      @(negedge clk);
    end while (!ps_of(k) && n < 5000);
    if (!ps_of(k)) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int n, h, cnt_e, cnt_c;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset: outputs low, boundary every 256 clks (edge) / 510 clks (centre).
    cnt_e = 0;
    cnt_c = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      cnt_e += int'(ps_e);
      cnt_c += int'(ps_c);
    end
    check("idle_edge_pulses", cnt_e, 2);
    check("idle_ctr_pulses", cnt_c, 1);
    check("idle_pwm_e", int'(pwm_e), 0);
    check("idle_pwm_c", int'(pwm_c), 0);

    // Shadow write + commit: applied at next boundary only.
    send(2'b00, 4'd3, 8'd64);
    send(2'b10, 4'd0, 8'd0);
    send(2'b01, 4'd3, 8'd1);
    check("commit_pending_set", int'(cp_e), 1);
    measure(0, 3, "ch3", n, h);
    check("ch3_period", n, 256);
    check("ch3_high", h, 64);
    check("commit_pending_clear", int'(cp_e), 0);

    // Uncommitted shadow has no effect; COMMIT in the boundary cycle lands one period later.
    send(2'b00, 4'd0, 8'd128);
    send(2'b01, 4'd0, 8'd1);
    measure(0, 0, "ch0_nocommit", n, h);
    check("ch0_nocommit_high", h, 0);
    wait_ps(0, "ch0_align");
    repeat (254) @(negedge clk);
    send(2'b10, 4'd0, 8'd0);
    check("late_commit_boundary", int'(ps_e), 1);
    check("late_commit_still_pending", int'(cp_e), 1);
    measure(0, 0, "ch0_late", n, h);
    check("ch0_late_high", h, 128);
    check("ch0_late_cleared", int'(cp_e), 0);

    // Centre-aligned period length.
    send(2'b00, 4'd1, 8'd100);
    send(2'b01, 4'd1, 8'd1);
    send(2'b10, 4'd0, 8'd0);
    measure(1, 1, "ctr_ch1", n, h);
    check("ctr_period", n, 510);

    // Prescaler reload 3: four clocks per count.
    send(2'b11, 4'd0, 8'd3);
    send(2'b00, 4'd5, 8'd10);
    send(2'b10, 4'd0, 8'd0);
    send(2'b01, 4'd5, 8'd1);
    measure(0, 5, "ch5", n, h);
    check("ch5_period", n, 1024);
    check("ch5_high", h, 40);
    send(2'b01, 4'd5, 8'd3);
    measure(0, 5, "ch5_inv", n, h);
    check("ch5_inv_high", h, 984);

    // Out-of-range addresses are dropped; reset mid-period clears everything, ignoring commands.
    send(2'b01, 4'd12, 8'd3);
    send(2'b00, 4'd15, 8'd255);
    repeat (40) @(negedge clk);
    reset = 1'b1;
    cmd_valid = 1'b1;
    cmd_data = {2'b10, 2'b00, 4'd0, 8'd0};
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data = '0;
    check("reset_pwm_e", int'(pwm_e), 0);
    check("reset_pwm_c", int'(pwm_c), 0);
    check("reset_cp_e", int'(cp_e), 0);
    check("reset_ps_e", int'(ps_e), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
